// File: rtl/gated_hold_bank.sv
// CH registered channels: capture on enable, otherwise hold (HOLD_MODE=1) or clear (HOLD_MODE=0).
// Define GATED_HOLD_TIMEOUT_EN for a per-channel idle timeout in hold mode with a one-cycle stale pulse.
module gated_hold_bank #(
    parameter int WIDTH     = 8,
    parameter int CH        = 4,
    parameter int HOLD_MODE = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] a,
    input  logic [CH-1:0]       enable,
    input  logic                clr,
    output logic [CH*WIDTH-1:0] y,
    output logic [CH-1:0]       valid,
    output logic [CH-1:0]       stale
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("gated_hold_bank: TIMEOUT must be in 1..255");
    end

`ifdef GATED_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [WIDTH-1:0] y_q;
        logic             v_q;
        logic             s_q;

        if (HOLD_MODE == 0) begin : g_clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q <= '0;
                    v_q <= 1'b0;
                end else if (clr) begin
                    y_q <= '0;
                    v_q <= 1'b0;
                end else if (enable[i]) begin
                    y_q <= a[i*WIDTH +: WIDTH];
                    v_q <= 1'b1;
                end else begin
                    y_q <= '0;
                    v_q <= 1'b0;
                end
            end
            assign s_q = 1'b0;
        end else begin : g_hold
`ifdef GATED_HOLD_TIMEOUT_EN
            logic [CW-1:0] cnt_q;
            logic          expire;

            // Expiry is the edge on which the idle count would reach TIMEOUT.
            assign expire = v_q && !enable[i] && (cnt_q == CW'(TIMEOUT - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q   <= '0;
                    v_q   <= 1'b0;
                    s_q   <= 1'b0;
                    cnt_q <= '0;
                end else if (clr) begin
                    y_q   <= '0;
                    v_q   <= 1'b0;
                    s_q   <= 1'b0;
                    cnt_q <= '0;
                end else if (enable[i]) begin
                    y_q   <= a[i*WIDTH +: WIDTH];
                    v_q   <= 1'b1;
                    s_q   <= 1'b0;
                    cnt_q <= '0;
                end else if (expire) begin
                    y_q   <= '0;
                    v_q   <= 1'b0;
                    s_q   <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    y_q   <= y_q;
                    v_q   <= v_q;
                    s_q   <= 1'b0;
                    cnt_q <= v_q ? cnt_q + CW'(1) : '0;
                end
            end
`else
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q <= '0;
                    v_q <= 1'b0;
                end else if (clr) begin
                    y_q <= '0;
                    v_q <= 1'b0;
                end else if (enable[i]) begin
                    y_q <= a[i*WIDTH +: WIDTH];
                    v_q <= 1'b1;
                end else begin
                    y_q <= y_q;
                    v_q <= v_q;
                end
            end
            assign s_q = 1'b0;
`endif
        end

        assign y[i*WIDTH +: WIDTH] = y_q;
        assign valid[i]            = v_q;
        assign stale[i]            = s_q;
    end

endmodule

// File: doc/gated_hold_bank.md
GATED_HOLD_BANK -- requirements
Module: gated_hold_bank

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel.
REQ-002 Parameter CH, default 4: number of independent channels.
REQ-003 Parameter HOLD_MODE, default 1: 1 means hold the last captured value while disabled; 0 means clear to zero while disabled.
REQ-004 Parameter TIMEOUT, default 15: consecutive disabled cycles before a held value expires; legal range 1..255.
REQ-005 clk  input  1: the single clock; all state updates on its rising edge.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 a  input  CH*WIDTH: channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 enable  input  CH: per-channel capture enable.
REQ-009 clr  input  1: synchronous clear of all channels.
REQ-010 y  output  CH*WIDTH: registered channel outputs, using the same packing as a.
REQ-011 valid  output  CH: channel i holds data captured since the last reset, clear or expiry.
REQ-012 stale  output  CH: one-cycle pulse when channel i's held value expires.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 Each channel SHALL evaluate the following priority every clock edge:
  - clr
  - enable[i]
  - HOLD_MODE behaviour
REQ-015 clr=1: y_i=0, valid[i]=0, idle counter=0, stale[i]=0, for every channel regardless of enable.
REQ-016 clr=0 and enable[i]=1: y_i<=a_i, valid[i]<=1, idle counter<=0; latency is one cycle from input to y.
REQ-017 HOLD_MODE=0, clr=0, enable[i]=0: y_i<=0 and valid[i]<=0 on the next edge; this is the registered equivalent of an "else y=0" gate.
REQ-018 HOLD_MODE=1, clr=0, enable[i]=0: y_i and valid[i] SHALL hold, with no latch inferred; hold is by flip-flop only.
REQ-019 Every register SHALL be assigned on every path through the sequential block.
REQ-020 Channels SHALL be fully independent; activity on channel i never alters channel j.
REQ-021 stale[i] SHALL be 0 in every cycle except the single expiry cycle defined in Configuration.
REQ-022 If enable[i] rises in the cycle expiry would occur, capture SHALL win: no expiry and no stale pulse.

Reset
REQ-023 On rst=1 the block SHALL asynchronously force y=0, valid=0, stale=0 and all idle counters to 0.
REQ-024 Reset SHALL override clr and enable and hold state for as long as it is asserted.
REQ-025 After rst deasserts, the first rising edge SHALL apply REQ-014 normally.
REQ-026 Reset during an in-progress idle count SHALL discard the count; no stale pulse is emitted for it.

Configuration
REQ-027 Macro GATED_HOLD_TIMEOUT_EN compiles in one idle counter per channel, ceil(log2(TIMEOUT+1)) bits wide, active only when HOLD_MODE=1.
REQ-028 With the macro, the idle counter SHALL behave as follows:
  - increments on each edge where valid[i]=1, enable[i]=0 and clr=0;
  - resets to 0 whenever valid[i]=0 or enable[i]=1.
REQ-029 With the macro, on the edge where the idle counter would reach TIMEOUT, the channel SHALL go to y_i=0, valid[i]=0, counter=0, and stale[i]=1 for exactly that one cycle.
REQ-030 Without the macro, no counters exist, stale SHALL be tied to 0, and held values persist indefinitely.
REQ-031 With HOLD_MODE=0, stale SHALL be 0 regardless of the macro.

Verification
REQ-032 Reset/capture (defaults): rst pulse, then enable=4'b0001 with a[7:0]=8'hA5 -> y[7:0]=8'hA5 and valid=4'b0001 one edge later; other channels stay 0.
REQ-033 Hold: after REQ-032, drop enable[0] for 10 cycles with a changing -> y[7:0] stays 8'hA5, valid[0]=1, stale=0.
REQ-034 Timeout (macro on, TIMEOUT=15): keep enable[0]=0 -> on the 15th disabled edge y[7:0]=0, valid[0]=0, stale[0]=1 for exactly one cycle. Repeat with enable[0]=1 on the would-be expiry cycle -> capture occurs and no stale pulse.
REQ-035 Clear priority: clr=1 with enable=4'b1111 and a=32'hDEADBEEF -> y=0 and valid=0 next edge.
REQ-036 HOLD_MODE=0: enable[2]=1 with a[23:16]=8'h3C, then enable[2]=0 -> y[23:16] is 8'h3C for one cycle, then 0; valid[2] follows it.
REQ-037 Asynchronous reset: assert rst mid-cycle during a hold with the idle counter at 7 -> y and valid go 0 immediately without waiting for a clock; after release, 15 further disabled cycles produce no stale pulse.
